// File: rtl/uart_receiver_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding and parameter defaults.
// The transmitter is expected to import the same package.
package uart_receiver_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

  localparam int unsigned BAUD_DIV_DEF    = 40;
  localparam int unsigned OVERSAMPLE_DEF  = 16;
  localparam int unsigned FIFO_DEPTH_DEF  = 4;
  localparam int unsigned SYNC_STAGES_DEF = 2;

  // Occupancy counter width: must be able to hold the value DEPTH itself.
  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// IO-side handshake of the UART receiver: pop/clear strobes, FIFO head and status.
interface uart_receiver_if #(
  parameter int unsigned COUNT_W = 3
);
  logic               RD;
  logic               CLR_ERR;
  logic [7:0]         DATA;
  logic               AVAIL;
  logic               FULL;
  logic [COUNT_W-1:0] COUNT;
  logic               FRAME_ERR;
  logic               OVERRUN;

  modport master (
    output RD, CLR_ERR,
    input  DATA, AVAIL, FULL, COUNT, FRAME_ERR, OVERRUN
  );

  modport slave (
    input  RD, CLR_ERR,
    output DATA, AVAIL, FULL, COUNT, FRAME_ERR, OVERRUN
  );
endinterface

// File: rtl/uart_receiver_sync_fifo.sv
// Small synchronous FIFO; a pop on empty is ignored, a push on full is accepted only
// when a pop frees a slot in the same cycle.
module uart_receiver_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_pop_s;
  logic             do_push_s;

  assign empty     = (count_r == {CW{1'b0}});
  assign full      = (count_r == CW'(DEPTH));
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);
  assign head      = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Storage, pointers (wrap naturally at power-of-two depth) and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {WIDTH{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end
endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receive front end: RX synchroniser, oversample tick generator, deframing FSM,
// receive FIFO and sticky framing/overrun flags.
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int unsigned BAUD_DIV    = BAUD_DIV_DEF,
  parameter int unsigned OVERSAMPLE  = OVERSAMPLE_DEF,
  parameter int unsigned FIFO_DEPTH  = FIFO_DEPTH_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic          CLK,
  input  logic          RESET_n,
  input  logic          RX,
  uart_receiver_if.slave io
);
  localparam int unsigned DIV_W  = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int unsigned SCNT_W = $clog2(OVERSAMPLE);
  localparam int unsigned CW     = count_width(FIFO_DEPTH);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   rx_s;
  logic [DIV_W-1:0]       div_r;
  logic                   tick_s;
  rx_state_e              state_r, state_n;
  logic [SCNT_W-1:0]      scnt_r, scnt_n;
  logic [2:0]             bit_r, bit_n;
  logic [7:0]             shift_r, shift_n;
  logic                   push_s;
  logic                   ferr_set_s;
  logic                   ovr_set_s;
  logic                   frame_err_r;
  logic                   overrun_r;
  logic [7:0]             head_s;
  logic [CW-1:0]          count_s;
  logic                   full_s;
  logic                   empty_s;

  assign rx_s   = sync_r[SYNC_STAGES-1];
  assign tick_s = (div_r == DIV_W'(BAUD_DIV - 1));

  // RX metastability chain, idling high.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) sync_r <= {SYNC_STAGES{1'b1}};
    else          sync_r <= {sync_r[SYNC_STAGES-2:0], RX};
  end

  // Free-running oversample tick divider.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n)    div_r <= {DIV_W{1'b0}};
    else if (tick_s) div_r <= {DIV_W{1'b0}};
    else             div_r <= div_r + DIV_W'(1);
  end

  // Deframer state, sample/bit counters and shift register.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_r <= ST_IDLE;
      scnt_r  <= {SCNT_W{1'b0}};
      bit_r   <= 3'd0;
      shift_r <= 8'h00;
    end else begin
      state_r <= state_n;
      scnt_r  <= scnt_n;
      bit_r   <= bit_n;
      shift_r <= shift_n;
    end
  end

  // Next-state logic; every decision is taken on an oversample tick only.
  always_comb begin
    state_n    = state_r;
    scnt_n     = scnt_r;
    bit_n      = bit_r;
    shift_n    = shift_r;
    push_s     = 1'b0;
    ferr_set_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (tick_s && !rx_s) begin
          state_n = ST_START;
          scnt_n  = {SCNT_W{1'b0}};
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_START: begin
        if (!tick_s) begin
          state_n = ST_START;
        end else if (scnt_r != SCNT_W'(OVERSAMPLE / 2 - 1)) begin
          scnt_n = scnt_r + SCNT_W'(1);
        end else if (!rx_s) begin
          state_n = ST_DATA;
          scnt_n  = {SCNT_W{1'b0}};
          bit_n   = 3'd0;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (!tick_s) begin
          state_n = ST_DATA;
        end else if (scnt_r != SCNT_W'(OVERSAMPLE - 1)) begin
          scnt_n = scnt_r + SCNT_W'(1);
        end else begin
          scnt_n  = {SCNT_W{1'b0}};
          shift_n = {rx_s, shift_r[7:1]};
          bit_n   = bit_r + 3'd1;
          if (bit_r == 3'd7) state_n = ST_STOP;
          else               state_n = ST_DATA;
        end
      end
      ST_STOP: begin
        if (!tick_s) begin
          state_n = ST_STOP;
        end else if (scnt_r != SCNT_W'(OVERSAMPLE - 1)) begin
          scnt_n = scnt_r + SCNT_W'(1);
        end else if (rx_s) begin
          push_s  = 1'b1;
          state_n = ST_IDLE;
        end else begin
          ferr_set_s = 1'b1;
          state_n    = ST_BREAK;
        end
      end
      ST_BREAK: begin
        if (tick_s && rx_s) state_n = ST_IDLE;
        else                state_n = ST_BREAK;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // When full, the FIFO is non-empty, so a raw RD is a real pop that makes room.
  assign ovr_set_s = push_s & full_s & ~io.RD;

  // Sticky error flags; a set in the same cycle as a clear wins.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      if (ferr_set_s)      frame_err_r <= 1'b1;
      else if (io.CLR_ERR) frame_err_r <= 1'b0;
      else                 frame_err_r <= frame_err_r;
      if (ovr_set_s)       overrun_r   <= 1'b1;
      else if (io.CLR_ERR) overrun_r   <= 1'b0;
      else                 overrun_r   <= overrun_r;
    end
  end

  uart_receiver_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RESET_n),
    .push  (push_s),
    .pop   (io.RD),
    .din   (shift_r),
    .head  (head_s),
    .count (count_s),
    .full  (full_s),
    .empty (empty_s)
  );

  assign io.DATA      = empty_s ? 8'h00 : head_s;
  assign io.AVAIL     = ~empty_s;
  assign io.FULL      = full_s;
  assign io.COUNT     = count_s;
  assign io.FRAME_ERR = frame_err_r;
  assign io.OVERRUN   = overrun_r;
endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 32 CLK per bit: table-driven single frames plus
// hand-written sequences for glitch, framing error/break, overrun and mid-frame reset.
module tb_uart_receiver;
  localparam int BIT = 32;

  typedef struct {
    logic [7:0] data;
    logic [7:0] exp_data;
    logic [2:0] exp_count;
  } vec_t;

  logic CLK = 1'b0;
  logic RESET_n;
  logic RX;
  int   tests = 0;
  int   fails = 0;

  always #5 CLK = ~CLK;

  uart_receiver_if #(.COUNT_W(3)) io ();

  uart_receiver #(
    .BAUD_DIV    (2),
    .OVERSAMPLE  (16),
    .FIFO_DEPTH  (4),
    .SYNC_STAGES (2)
  ) dut (
    .CLK     (CLK),
    .RESET_n (RESET_n),
    .RX      (RX),
    .io      (io)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " DATA"},      32'(io.DATA),      32'h0);
    check({tag, " AVAIL"},     32'(io.AVAIL),     32'h0);
    check({tag, " FULL"},      32'(io.FULL),      32'h0);
    check({tag, " COUNT"},     32'(io.COUNT),     32'h0);
    check({tag, " FRAME_ERR"}, 32'(io.FRAME_ERR), 32'h0);
    check({tag, " OVERRUN"},   32'(io.OVERRUN),   32'h0);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RX = f[i];
      repeat (BIT) @(negedge CLK);
    end
  endtask

  task automatic rd_pulse();
    io.RD = 1'b1;
    @(negedge CLK);
    io.RD = 1'b0;
  endtask

  task automatic clr_pulse();
    io.CLR_ERR = 1'b1;
    @(negedge CLK);
    io.CLR_ERR = 1'b0;
  endtask

  task automatic read_expect(input string name, input logic [7:0] exp);
    check(name, 32'(io.DATA), 32'(exp));
    rd_pulse();
  endtask

  vec_t vecs [5];
  int   lat;
  bit   found;

  initial begin
    vecs[0] = '{data: 8'hA5, exp_data: 8'hA5, exp_count: 3'd1};
    vecs[1] = '{data: 8'h00, exp_data: 8'h00, exp_count: 3'd1};
    vecs[2] = '{data: 8'hFF, exp_data: 8'hFF, exp_count: 3'd1};
    vecs[3] = '{data: 8'h5A, exp_data: 8'h5A, exp_count: 3'd1};
    vecs[4] = '{data: 8'h81, exp_data: 8'h81, exp_count: 3'd1};

    io.RD = 1'b0;
    io.CLR_ERR = 1'b0;
    RX = 1'b1;
    RESET_n = 1'b0;

    // 1: reset with RX toggling, then release idle
    for (int i = 0; i < 12; i++) begin
      RX = ~RX;
      @(negedge CLK);
    end
    check_idle_outputs("reset");
    RX = 1'b1;
    RESET_n = 1'b1;
    repeat (2 * BIT) @(negedge CLK);
    check("idle AVAIL", 32'(io.AVAIL), 32'h0);

    // 2: table of single frames with latency bound and read-back
    for (int v = 0; v < 5; v++) begin
      lat = -1;
      fork
        send_frame(vecs[v].data, 1'b1);
        begin
          for (int c = 1; c <= 10 * BIT; c++) begin
            @(negedge CLK);
            if (io.AVAIL && lat < 0) lat = c;
          end
        end
      join
      check($sformatf("vec%0d latency<=309", v), 32'(lat >= 300 && lat <= 309), 32'h1);
      check($sformatf("vec%0d DATA", v), 32'(io.DATA), 32'(vecs[v].exp_data));
      check($sformatf("vec%0d COUNT", v), 32'(io.COUNT), 32'(vecs[v].exp_count));
      check($sformatf("vec%0d AVAIL", v), 32'(io.AVAIL), 32'h1);
      rd_pulse();
      check($sformatf("vec%0d AVAIL after RD", v), 32'(io.AVAIL), 32'h0);
      check($sformatf("vec%0d DATA after RD", v), 32'(io.DATA), 32'h0);
    end
    rd_pulse();
    check("RD on empty COUNT", 32'(io.COUNT), 32'h0);

    // 3: short low glitch is not a start bit
    RX = 1'b0;
    repeat (6) @(negedge CLK);
    RX = 1'b1;
    repeat (2 * BIT) @(negedge CLK);
    check("glitch COUNT", 32'(io.COUNT), 32'h0);
    check("glitch FRAME_ERR", 32'(io.FRAME_ERR), 32'h0);
    send_frame(8'h96, 1'b1);
    check("post-glitch DATA", 32'(io.DATA), 32'h96);
    rd_pulse();

    // 4: bad stop bit, held break gives a single error
    send_frame(8'h3C, 1'b0);
    check("ferr FRAME_ERR", 32'(io.FRAME_ERR), 32'h1);
    check("ferr COUNT", 32'(io.COUNT), 32'h0);
    clr_pulse();
    check("ferr cleared", 32'(io.FRAME_ERR), 32'h0);
    repeat (20 * BIT) @(negedge CLK);
    check("break single error", 32'(io.FRAME_ERR), 32'h0);
    RX = 1'b1;
    repeat (2 * BIT) @(negedge CLK);
    send_frame(8'h55, 1'b1);
    check("after break DATA", 32'(io.DATA), 32'h55);
    check("after break FRAME_ERR", 32'(io.FRAME_ERR), 32'h0);
    rd_pulse();

    // 5: overrun, drain, then refill with a pop in the push cycle
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    check("ovr FULL", 32'(io.FULL), 32'h1);
    check("ovr OVERRUN", 32'(io.OVERRUN), 32'h1);
    check("ovr COUNT", 32'(io.COUNT), 32'h4);
    for (int i = 1; i <= 4; i++) read_expect($sformatf("ovr read%0d", i), 8'(i));
    check("ovr drained AVAIL", 32'(io.AVAIL), 32'h0);
    clr_pulse();
    check("ovr cleared", 32'(io.OVERRUN), 32'h0);
    for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1);
    check("refill FULL", 32'(io.FULL), 32'h1);
    found = 1'b0;
    fork
      send_frame(8'h99, 1'b1);
      begin
        for (int c = 0; c < 10 * BIT && !found; c++) begin
          @(negedge CLK);
          if (dut.push_s) begin
            found = 1'b1;
            rd_pulse();
          end
        end
      end
    join
    check("push cycle found", 32'(found), 32'h1);
    check("push+pop COUNT", 32'(io.COUNT), 32'h4);
    check("push+pop OVERRUN", 32'(io.OVERRUN), 32'h0);
    read_expect("pp read11", 8'h11);
    read_expect("pp read12", 8'h12);
    read_expect("pp read13", 8'h13);
    read_expect("pp read99", 8'h99);
    check("pp drained COUNT", 32'(io.COUNT), 32'h0);

    // 6: reset during data bit 3 flushes FIFO and aborts the frame
    send_frame(8'h77, 1'b1);
    check("pre-reset COUNT", 32'(io.COUNT), 32'h1);
    RX = 1'b0;
    repeat (BIT) @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      RX = i[0];
      repeat (BIT) @(negedge CLK);
    end
    RX = 1'b1;
    repeat (BIT / 2) @(negedge CLK);
    RESET_n = 1'b0;
    repeat (3) @(negedge CLK);
    check_idle_outputs("mid-frame reset");
    RESET_n = 1'b1;
    repeat (8 * BIT) @(negedge CLK);
    check("post-reset no push", 32'(io.COUNT), 32'h0);
    send_frame(8'hC3, 1'b1);
    check("post-reset DATA", 32'(io.DATA), 32'hC3);
    check("post-reset COUNT", 32'(io.COUNT), 32'h1);
    check("post-reset FRAME_ERR", 32'(io.FRAME_ERR), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
